shift_pattern_detector: RTL and testbench
=========================================

// Module: shift_pattern_detector
// PURPOSE
//  Serial bit-pattern detector, parametrised successor of the fixed 4-bit "0110" shift detector.
//  Pattern width is a parameter. Pattern and don't-care mask are loaded at runtime.
//  Overlapping and non-overlapping match modes are selectable; a saturating match counter is included.
//  Sits on a serial input stream (din/din_valid) and drives a one-cycle registered match pulse (dout).
// PARAMETERS
//  PAT_W        4        pattern length in bits (>=2)
//  CNT_W        8        match counter width (>=1)
//  DEFAULT_PAT  4'b0110  pattern after reset ([PAT_W-1:0]; MSB = oldest bit)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  din        in   1      serial data bit
//  din_valid  in   1      din sampled on this posedge only when 1
//  pat_load   in   1      load pat_in/mask_in, flush history
//  pat_in     in   PAT_W  new pattern (MSB = oldest bit)
//  mask_in    in   PAT_W  1 = compare bit, 0 = don't care
//  overlap    in   1      1 = overlapping matches, 0 = non-overlapping
//  clear      in   1      synchronous clear of match_cnt/cnt_sat
//  dout       out  1      match pulse, registered
//  match_cnt  out  CNT_W  number of matches, saturating
//  cnt_sat    out  1      sticky, set when match_cnt reaches all-ones
// BEHAVIOUR
//  Reset: sr=0, fill=0, pat_reg=DEFAULT_PAT, mask_reg=all ones, dout=0, match_cnt=0, cnt_sat=0, state=FILL.
//  Shift: on posedge with din_valid=1: sr_nx = {sr[PAT_W-2:0], din}; sr <= sr_nx.
//   fill increments, saturating at PAT_W.
//  FSM, 2 states:
//   FILL  (fill < PAT_W): no match possible; goes to ARMED when fill reaches PAT_W.
//   ARMED: match = din_valid && (((sr_nx ^ pat_reg) & mask_reg) == 0).
//  Latency: dout <= match at the same posedge that samples the final pattern bit.
//   dout is high exactly one cycle; it is 0 in every cycle without a match.
//  overlap=1: after a match, stay ARMED (e.g. "0110110" gives 2 matches).
//  overlap=0: after a match, fill <= 0 and state goes to FILL; PAT_W fresh valid bits are needed.
//   overlap is sampled every cycle; changing it mid-stream affects only subsequent matches.
//  din_valid=0 cycles: sr, fill and state hold; dout=0. Gaps do not break a pattern.
//  pat_load=1: pat_reg<=pat_in, mask_reg<=mask_in, sr<=0, fill<=0, state<=FILL, dout<=0.
//   Takes priority over din_valid in the same cycle; that bit is dropped.
//  mask_reg all-zero: every valid bit in ARMED matches (documented, not an error).
//  Counter: on match, match_cnt+1 unless already all-ones; cnt_sat <= 1 when it reaches all-ones.
//  clear=1: match_cnt<=0, cnt_sat<=0. clear wins over a coincident match (count stays 0).
//   dout still pulses for that match.
//  Reset asserted mid-stream: all state returns to reset values immediately (async).
//   A loaded pattern is lost and pat_reg reverts to DEFAULT_PAT.
// CONFIGURATION
//  SHIFT_DET_STICKY_EN defined: adds output det_sticky (1 bit).
//   Reset 0; set on the posedge of any match; cleared by clear or pat_load.
//   If set and clear occur in the same cycle, clear wins.
//  Not defined: port det_sticky absent, no extra logic; all other behaviour identical.
// TESTING  (PAT_W=4, defaults unless noted; din_valid=1 unless noted)
//  1. Reset, overlap=1, stream 0,1,1,0 -> dout=1 for one cycle after 4th bit edge; match_cnt=1.
//  2. Stream 0,1,0,1 -> dout stays 0; match_cnt unchanged.
//  3. Stream 0,1,1,0,1,1,0: overlap=1 -> pulses on bits 4 and 7, cnt+=2; overlap=0 -> pulse on bit 4 only, cnt+=1.
//  4. Stream 0,1,1,0 with din_valid=0 gaps between bits -> one pulse, on the edge of the final valid bit.
//     pat_load asserted mid-pattern -> no pulse until 4 new bits arrive.
//  5. pat_load with pat_in=1001, mask_in=1001 -> 1001 matches and 1111 matches, 0111 does not.
//  6. CNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1; clear -> 0,0; clear coincident with match -> match_cnt=0, dout=1.
//     rst_n pulsed mid-stream -> all outputs 0 at once.
//     With SHIFT_DET_STICKY_EN: det_sticky=1 after first match, 0 after clear.

Source files
------------

// File: rtl/shift_pattern_detector.sv
// Serial pattern detector with runtime pattern/mask, overlap mode and saturating match counter.
// Optional det_sticky output is enabled by defining SHIFT_DET_STICKY_EN.
module shift_pattern_detector #(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(4'b0110)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  input  logic             overlap,
  input  logic             clear,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
`ifdef SHIFT_DET_STICKY_EN
  ,
  output logic             det_sticky
`endif
);

  typedef enum logic {FILL, ARMED} state_t;

  localparam int               FW        = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PAT_W);
  localparam logic [FW-1:0]    FILL_LAST = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_W-1:0]   sr_q, sr_d, sr_nx;
  logic [PAT_W-1:0]   pat_reg, mask_reg;
  logic [CNT_W-1:0]   cnt_d;
  logic               sat_d;
  logic               window_full;
  logic               match;

  // The window is complete either when already armed or when this bit is the last fill bit,
  // so the pulse lands on the same edge that samples the final pattern bit.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    sr_nx       = {sr_q[PAT_W-2:0], din};
    window_full = (state_q == ARMED) || (fill_q == FILL_LAST);
    match       = !pat_load && din_valid && window_full &&
                  (((sr_nx ^ pat_reg) & mask_reg) == '0);
    state_d     = state_q;
    fill_d      = fill_q;
    sr_d        = sr_q;

    if (pat_load) begin
      sr_d    = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (din_valid) begin
      sr_d = sr_nx;
      if (match && !overlap) begin
        fill_d  = '0;
        state_d = FILL;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
        if (fill_d == FILL_FULL) state_d = ARMED;
      end
    end
  end

  always_comb begin
    cnt_d = match_cnt;
    sat_d = cnt_sat;
    if (clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      cnt_d = match_cnt + CNT_W'(1);
      if (cnt_d == CNT_MAX) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      fill_q    <= '0;
      sr_q      <= '0;
      pat_reg   <= DEFAULT_PAT;
      mask_reg  <= '1;
      dout      <= 1'b0;
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= state_d;
      fill_q    <= fill_d;
      sr_q      <= sr_d;
      dout      <= match;
      match_cnt <= cnt_d;
      cnt_sat   <= sat_d;
      if (pat_load) begin
        pat_reg  <= pat_in;
        mask_reg <= mask_in;
      end
    end
  end

`ifdef SHIFT_DET_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_sticky <= 1'b0;
    end else if (clear || pat_load) begin
      det_sticky <= 1'b0;
    end else if (match) begin
      det_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_pattern_detector.sv
// Directed bench for shift_pattern_detector: a window-based reference model checked every cycle,
// plus hand-computed literal expectations. Two instances share stimulus (CNT_W=8 and CNT_W=2).
module tb_shift_pattern_detector;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             din, din_valid, pat_load, overlap, clear;
  logic [PAT_W-1:0] pat_in, mask_in;
  logic             dout, dout_s, sat, sat_s;
  logic [7:0]       cnt;
  logic [1:0]       cnt_s;
`ifdef SHIFT_DET_STICKY_EN
  logic             sticky, sticky_s;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  shift_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap), .clear(clear),
    .dout(dout), .match_cnt(cnt), .cnt_sat(sat)
`ifdef SHIFT_DET_STICKY_EN
    , .det_sticky(sticky)
`endif
  );

  shift_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .overlap(overlap), .clear(clear),
    .dout(dout_s), .match_cnt(cnt_s), .cnt_sat(sat_s)
`ifdef SHIFT_DET_STICKY_EN
    , .det_sticky(sticky_s)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: history of valid bits since the last flush, compared as a window.
  bit               hist[$];
  logic [PAT_W-1:0] m_pat  = 4'b0110;
  logic [PAT_W-1:0] m_mask = 4'b1111;
  int               e_cnt  = 0;
  bit               e_dout = 1'b0;
  bit               e_sticky = 1'b0;
  bit               hit;

  function automatic bit window_match();
    int base = hist.size() - PAT_W;
    for (int i = 0; i < PAT_W; i++) begin
      if (m_mask[PAT_W-1-i] && (hist[base+i] != m_pat[PAT_W-1-i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_pat    = 4'b0110;
      m_mask   = 4'b1111;
      e_cnt    = 0;
      e_dout   = 1'b0;
      e_sticky = 1'b0;
    end else begin
      hit = 1'b0;
      if (pat_load) begin
        m_pat  = pat_in;
        m_mask = mask_in;
        hist.delete();
      end else if (din_valid) begin
        hist.push_back(din);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        if (hist.size() == PAT_W && window_match()) begin
          hit = 1'b1;
          if (!overlap) hist.delete();
        end
      end
      e_dout = hit;
      if (clear) begin
        e_cnt    = 0;
        e_sticky = 1'b0;
      end else if (hit) begin
        e_cnt    = e_cnt + 1;
        e_sticky = 1'b1;
      end
      if (pat_load) e_sticky = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", 32'(dout), 32'(e_dout));
      check("match_cnt", 32'(cnt), (e_cnt > 255) ? 32'd255 : 32'(e_cnt));
      check("cnt_sat", 32'(sat), 32'(e_cnt >= 255));
      check("dout_small", 32'(dout_s), 32'(e_dout));
      check("match_cnt_small", 32'(cnt_s), (e_cnt > 3) ? 32'd3 : 32'(e_cnt));
      check("cnt_sat_small", 32'(sat_s), 32'(e_cnt >= 3));
`ifdef SHIFT_DET_STICKY_EN
      check("det_sticky", 32'(sticky), 32'(e_sticky));
      check("det_sticky_small", 32'(sticky_s), 32'(e_sticky));
`endif
    end
  end

  task automatic step(input logic v, input logic b);
    din_valid = v;
    din       = b;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    pat_load  = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
    pat_in   = p;
    mask_in  = m;
    pat_load = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b1; din = 1'b0; din_valid = 1'b0; pat_load = 1'b0;
    overlap = 1'b1; clear = 1'b0; pat_in = '0; mask_in = '0;
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("reset dout", 32'(dout), 0);
    check("reset cnt", 32'(cnt), 0);
    check("reset sat", 32'(sat), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic overlap match on 0110 then a gap cycle
    feed(16'b011, 3);
    check("t1 bit3 dout", 32'(dout), 0);
    step(1'b1, 1'b0);
    check("t1 match dout", 32'(dout), 1);
    check("t1 cnt", 32'(cnt), 1);
    step(1'b0, 1'b0);
    check("t1 gap dout", 32'(dout), 0);

    // Non-matching stream
    feed(16'b0101, 4);
    check("t2 dout", 32'(dout), 0);
    check("t2 cnt", 32'(cnt), 1);

    // Overlapping: pulses on bits 4 and 7
    load(4'b0110, 4'b1111);
    feed(16'b0110, 4);
    check("t3 ov bit4", 32'(dout), 1);
    feed(16'b110, 3);
    check("t3 ov bit7", 32'(dout), 1);
    check("t3 ov cnt", 32'(cnt), 3);
    check("t3 small cnt", 32'(cnt_s), 3);
    check("t3 small sat", 32'(sat_s), 1);

    // Non-overlapping: pulse on bit 4 only
    overlap = 1'b0;
    load(4'b0110, 4'b1111);
    feed(16'b0110, 4);
    check("t3 nov bit4", 32'(dout), 1);
    feed(16'b110, 3);
    check("t3 nov bit7", 32'(dout), 0);
    check("t3 nov cnt", 32'(cnt), 4);
    overlap = 1'b1;

    // Gaps between pattern bits
    load(4'b0110, 4'b1111);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b1, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b0);
    check("t4 gap match", 32'(dout), 1);
    step(1'b0, 1'b0);
    check("t4 after gap", 32'(dout), 0);

    // pat_load mid-pattern drops the coincident bit and flushes history
    feed(16'b011, 3);
    pat_in = 4'b0110; mask_in = 4'b1111; pat_load = 1'b1;
    step(1'b1, 1'b0);
    check("t4 load drop", 32'(dout), 0);
    step(1'b1, 1'b0);
    check("t4 fresh bit1", 32'(dout), 0);
    feed(16'b11, 2);
    step(1'b1, 1'b0);
    check("t4 fresh match", 32'(dout), 1);
    check("t4 cnt", 32'(cnt), 6);

    // Masked pattern 1001 / 1001
    load(4'b1001, 4'b1001);
    feed(16'b1001, 4);
    check("t5 1001", 32'(dout), 1);
    load(4'b1001, 4'b1001);
    feed(16'b1111, 4);
    check("t5 1111", 32'(dout), 1);
    load(4'b1001, 4'b1001);
    feed(16'b0111, 4);
    check("t5 0111", 32'(dout), 0);

    // All-zero mask: every valid bit matches once the window is full
    load(4'b0000, 4'b0000);
    feed(16'b101, 3);
    check("t5 mask0 fill", 32'(dout), 0);
    step(1'b1, 1'b0);
    check("t5 mask0 bit4", 32'(dout), 1);
    step(1'b1, 1'b1);
    check("t5 mask0 bit5", 32'(dout), 1);
    check("t5 cnt", 32'(cnt), 10);

    // Clear, then clear coincident with a match
    clear = 1'b1;
    step(1'b0, 1'b0);
    check("t6 clr cnt", 32'(cnt), 0);
    check("t6 clr small sat", 32'(sat_s), 0);
    load(4'b0110, 4'b1111);
    feed(16'b011, 3);
    clear = 1'b1;
    step(1'b1, 1'b0);
    check("t6 clr+match dout", 32'(dout), 1);
    check("t6 clr+match cnt", 32'(cnt), 0);
`ifdef SHIFT_DET_STICKY_EN
    check("t6 sticky clr wins", 32'(sticky), 0);
    feed(16'b110, 3);
    check("t6 sticky set", 32'(sticky), 1);
    clear = 1'b1;
    step(1'b0, 1'b0);
    check("t6 sticky cleared", 32'(sticky), 0);
`endif

    // Five matches saturate the 2-bit counter
    clear = 1'b1;
    load(4'b0110, 4'b1111);
    feed(16'b0110110110110110, 16);
    check("t6 cnt5", 32'(cnt), 5);
    check("t6 small cnt sat", 32'(cnt_s), 3);
    check("t6 small sat", 32'(sat_s), 1);
    check("t6 main sat", 32'(sat), 0);

    // Async reset mid-stream, then default pattern is back
    load(4'b1001, 4'b1111);
    feed(16'b1001, 4);
    check("t6 pre-reset dout", 32'(dout), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst dout", 32'(dout), 0);
    check("t6 rst cnt", 32'(cnt), 0);
    check("t6 rst small cnt", 32'(cnt_s), 0);
    check("t6 rst small sat", 32'(sat_s), 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    feed(16'b0110, 4);
    check("t6 default pat restored", 32'(dout), 1);
    step(1'b0, 1'b0);

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
